// File: rtl/polylut_out_pkg.sv
// Shared types and score comparison helpers for the polylut output stage.
// Results carry a class index plus the winning score.
package polylut_out_pkg;

   localparam int NUM_CLASSES = 5;
   localparam int SCORE_W     = 5;
   localparam int CLASS_W     = 3;

   typedef logic [SCORE_W-1:0] score_t;
   typedef logic [CLASS_W-1:0] class_t;

   typedef struct packed {
      class_t cls;
      score_t score;
   } result_t;

   function automatic logic score_gt(input score_t a, input score_t b, input logic signed_mode);
      logic gt_s;
      if (signed_mode) begin
         gt_s = ($signed(a) > $signed(b));
      end else begin
         gt_s = (a > b);
      end
      return gt_s;
   endfunction

   // The higher-index candidate wins only when strictly greater, so ties keep the lower index.
   function automatic result_t pick_max(input result_t lo, input result_t hi, input logic signed_mode);
      result_t win_s;
      if (score_gt(hi.score, lo.score, signed_mode)) begin
         win_s = hi;
      end else begin
         win_s = lo;
      end
      return win_s;
   endfunction

endpackage

// File: rtl/polylut_res_fifo.sv
// First-word-fall-through result FIFO; head is visible whenever empty is low.
// Pointers carry an extra MSB to tell full from empty.
module polylut_res_fifo
   import polylut_out_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  result_t wdata,
   output logic    full,
   input  logic    pop,
   output logic    empty,
   output result_t rdata
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0] wr_ptr_r;
   logic [AW:0] rd_ptr_r;
   result_t     mem_r [DEPTH];
   logic        pop_s;
   logic        push_s;

   assign empty  = (wr_ptr_r == rd_ptr_r);
   assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign pop_s  = pop && !empty;
   assign push_s = push && (!full || pop_s);
   assign rdata  = mem_r[rd_ptr_r[AW-1:0]];

   // Storage and pointer update; a push into a full FIFO is legal only alongside a pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
            wr_ptr_r                <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/polylut_argmax_out.sv
// Output stage behind the polylut network: re-times the sample strobe, picks the
// winning class with a two-stage registered argmax and buffers results; losses are counted.
module polylut_argmax_out
   import polylut_out_pkg::*;
#(
   parameter int PIPE_LAT     = 5,
   parameter int SCORE_SIGNED = 1,
   parameter int FIFO_DEPTH   = 4,
   parameter int DROP_W       = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   input  logic [NUM_CLASSES*SCORE_W-1:0] score_in,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [CLASS_W-1:0]             out_class,
   output logic [SCORE_W-1:0]             out_score,
   output logic                           overflow,
   output logic [DROP_W-1:0]              drop_cnt
);

   localparam logic              SIGNED_MODE = (SCORE_SIGNED != 0);
   localparam logic [DROP_W-1:0] DROP_ONE    = {{(DROP_W-1){1'b0}}, 1'b1};
   localparam logic [DROP_W-1:0] DROP_MAX    = {DROP_W{1'b1}};

   logic [PIPE_LAT-1:0] vld_r;
   result_t             cls_s [NUM_CLASSES];
   logic                a_vld_r;
   result_t             a01_r, a23_r, a4_r;
   result_t             ab_s, b_win_s;
   logic                b_vld_r;
   result_t             b_res_r;
   logic                fifo_full_s, fifo_empty_s;
   result_t             head_s;
   logic                pop_s, drop_s;
   logic                overflow_r;
   logic [DROP_W-1:0]   drop_cnt_r;

   // Unpack the score bus into indexed candidates.
   always_comb begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
         cls_s[k].cls   = class_t'(k);
         cls_s[k].score = score_in[k*SCORE_W +: SCORE_W];
      end
   end

   // Valid delay line matching the network depth; the last tap lines up with score_in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_r <= '0;
      end else begin
         vld_r <= {vld_r[PIPE_LAT-2:0], in_valid};
      end
   end

   assign ab_s    = pick_max(a01_r, a23_r, SIGNED_MODE);
   assign b_win_s = pick_max(ab_s, a4_r, SIGNED_MODE);

   // Argmax stages A and B, valid travelling alongside the data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_vld_r <= 1'b0;
         a01_r   <= '0;
         a23_r   <= '0;
         a4_r    <= '0;
         b_vld_r <= 1'b0;
         b_res_r <= '0;
      end else begin
         a_vld_r <= vld_r[PIPE_LAT-1];
         a01_r   <= pick_max(cls_s[0], cls_s[1], SIGNED_MODE);
         a23_r   <= pick_max(cls_s[2], cls_s[3], SIGNED_MODE);
         a4_r    <= cls_s[4];
         b_vld_r <= a_vld_r;
         b_res_r <= b_win_s;
      end
   end

   polylut_res_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (b_vld_r),
      .wdata (b_res_r),
      .full  (fifo_full_s),
      .pop   (pop_s),
      .empty (fifo_empty_s),
      .rdata (head_s)
   );

   assign out_valid = !fifo_empty_s;
   assign pop_s     = out_valid && out_ready;
   assign drop_s    = b_vld_r && fifo_full_s && !pop_s;
   assign out_class = head_s.cls;
   assign out_score = head_s.score;

   // Loss reporting: the network cannot stall, so a result arriving at a full FIFO is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_r <= 1'b0;
         drop_cnt_r <= '0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
         if (drop_cnt_r != DROP_MAX) begin
            drop_cnt_r <= drop_cnt_r + DROP_ONE;
         end
      end
   end

   assign overflow = overflow_r;
   assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_polylut_argmax_out.sv
// Directed bench for polylut_argmax_out; a 5-deep score line emulates the network latency.
module tb_polylut_argmax_out;
   import polylut_out_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [24:0] score_in = '0;
   logic        out_ready = 1'b0;
   logic        out_valid, out_valid_u;
   logic [2:0]  out_class, out_class_u;
   logic [4:0]  out_score, out_score_u;
   logic        overflow, overflow_u;
   logic [15:0] drop_cnt, drop_cnt_u;

   int checks = 0;
   int failures = 0;
   logic [24:0] line_q [6];
   logic [7:0]  got_q [$];
   logic [7:0]  exp_a [4];
   int          seen;

   always #5 clk = ~clk;

   polylut_argmax_out #(.SCORE_SIGNED(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .score_in(score_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
      .out_score(out_score), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   polylut_argmax_out #(.SCORE_SIGNED(0)) dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .score_in(score_in),
      .out_valid(out_valid_u), .out_ready(out_ready), .out_class(out_class_u),
      .out_score(out_score_u), .overflow(overflow_u), .drop_cnt(drop_cnt_u)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [24:0] pk(input int c0, input int c1, input int c2, input int c3, input int c4);
      return {c4[4:0], c3[4:0], c2[4:0], c1[4:0], c0[4:0]};
   endfunction

   // Class k wins with score w; all others hold -3.
   function automatic logic [24:0] mk(input int k, input int w);
      logic [24:0] r;
      for (int i = 0; i < 5; i++) r[i*5 +: 5] = (i == k) ? w[4:0] : 5'b11101;
      return r;
   endfunction

   function automatic logic [7:0] ex(input int k, input int w);
      return {k[2:0], w[4:0]};
   endfunction

   // One cycle: present in_valid now, the sample's scores five cycles later; log pops.
   task automatic tick(input logic v, input logic [24:0] s);
      in_valid = v;
      for (int i = 5; i > 0; i--) line_q[i] = line_q[i-1];
      line_q[0] = s;
      score_in  = line_q[5];
      if (out_valid && out_ready) got_q.push_back({out_class, out_score});
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 6; i++) line_q[i] = '0;

      // 1: reset with in_valid toggling
      for (int i = 0; i < 6; i++) tick(i[0], mk(1, 5));
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_class", {29'd0, out_class}, 32'd0);
      check("rst_out_score", {27'd0, out_score}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
      check("rst_u_drop_cnt", {16'd0, drop_cnt_u}, 32'd0);
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, '0);
         if (out_valid) seen++;
      end
      check("idle_after_release", seen, 32'd0);

      // 2: latency and argmax
      tick(1'b1, pk(1, 7, 7, -2, 3));
      repeat (6) tick(1'b0, '0);
      check("lat_t7_not_valid", {31'd0, out_valid}, 32'd0);
      tick(1'b0, '0);
      check("lat_t8_valid", {31'd0, out_valid}, 32'd1);
      check("lat_result", {24'd0, out_class, out_score}, {24'd0, ex(1, 7)});
      out_ready = 1'b1; tick(1'b0, '0); out_ready = 1'b0;
      check("lat_popped_empty", {31'd0, out_valid}, 32'd0);

      // 3: signed values and ties
      tick(1'b1, pk(-16, -16, -16, -16, -16));
      repeat (7) tick(1'b0, '0);
      check("tie_all_neg16", {24'd0, out_class, out_score}, {24'd0, ex(0, -16)});
      out_ready = 1'b1; tick(1'b0, '0); out_ready = 1'b0;
      tick(1'b1, pk(-1, -3, -5, -7, 15));
      repeat (7) tick(1'b0, '0);
      check("signed_c4_wins", {24'd0, out_class, out_score}, {24'd0, ex(4, 15)});
      out_ready = 1'b1; tick(1'b0, '0); out_ready = 1'b0;
      tick(1'b1, pk(31, 0, 0, 0, 0));
      repeat (7) tick(1'b0, '0);
      check("unsigned_31_wins", {24'd0, out_class_u, out_score_u}, {24'd0, ex(0, 31)});
      check("signed_31_is_neg", {24'd0, out_class, out_score}, {24'd0, ex(1, 0)});
      out_ready = 1'b1; tick(1'b0, '0); out_ready = 1'b0;

      // 4: streaming 20 back-to-back samples
      got_q.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) tick(1'b1, mk(i % 5, (i % 10) + 1));
      repeat (12) tick(1'b0, '0);
      out_ready = 1'b0;
      check("stream_count", got_q.size(), 32'd20);
      for (int i = 0; i < 20 && i < got_q.size(); i++)
         check($sformatf("stream_res%0d", i), {24'd0, got_q[i]}, {24'd0, ex(i % 5, (i % 10) + 1)});
      check("stream_drop_cnt", {16'd0, drop_cnt}, 32'd0);
      check("stream_overflow", {31'd0, overflow}, 32'd0);

      // 5: overflow with consumer stalled
      for (int i = 0; i < 6; i++) tick(1'b1, mk(i % 5, i + 2));
      repeat (10) tick(1'b0, '0);
      check("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd2);
      check("ovf_sticky", {31'd0, overflow}, 32'd1);
      check("ovf_head_held", {23'd0, out_valid, out_class, out_score}, {23'd0, 1'b1, ex(0, 2)});
      got_q.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 10 && got_q.size() < 4; i++) tick(1'b0, '0);
      out_ready = 1'b0;
      check("ovf_drain_count", got_q.size(), 32'd4);
      for (int i = 0; i < 4 && i < got_q.size(); i++)
         check($sformatf("ovf_res%0d", i), {24'd0, got_q[i]}, {24'd0, ex(i, i + 2)});
      check("ovf_drained_empty", {31'd0, out_valid}, 32'd0);

      // 6: full FIFO with push and pop in the same cycle
      got_q.delete();
      for (int c = 0; c < 16; c++) begin
         out_ready = (c == 11);
         tick(c < 5, (c < 5) ? mk(4 - c, 10 - c) : '0);
      end
      out_ready = 1'b0;
      check("fpp_drop_cnt", {16'd0, drop_cnt}, 32'd2);
      check("fpp_one_pop", got_q.size(), 32'd1);
      if (got_q.size() > 0) check("fpp_first", {24'd0, got_q[0]}, {24'd0, ex(4, 10)});
      got_q.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 10 && got_q.size() < 4; i++) tick(1'b0, '0);
      out_ready = 1'b0;
      check("fpp_drain_count", got_q.size(), 32'd4);
      for (int i = 0; i < 4; i++) exp_a[i] = ex(3 - i, 9 - i);
      for (int i = 0; i < 4 && i < got_q.size(); i++)
         check($sformatf("fpp_res%0d", i), {24'd0, got_q[i]}, {24'd0, exp_a[i]});

      // Reset asserted mid-stream
      for (int c = 0; c < 10; c++) tick(1'b1, mk(c % 5, 3));
      check("mid_has_data", {31'd0, out_valid}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
      check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
      check("mid_rst_head", {24'd0, out_class, out_score}, 32'd0);
      @(posedge clk); #1;
      tick(1'b1, mk(2, 4));
      tick(1'b0, mk(2, 4));
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, '0);
         if (out_valid) seen++;
      end
      check("mid_release_empty", seen, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
